// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multicycle control unit.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EX_R    = 3'd2,
        S_EX_ADDR = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_BRANCH  = 3'd6,
        S_TRAP    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LDUR = 3'd1,
        CLS_STUR = 3'd2,
        CLS_CBZ  = 3'd3,
        CLS_B    = 3'd4,
        CLS_ILL  = 3'd5
    } cls_e;

    // Opcode match patterns: (opcode & MASK) == VAL
    localparam logic [10:0] OP_R_VAL    = 11'b10001010000;
    localparam logic [10:0] OP_R_MASK   = 11'b10011110111;
    localparam logic [10:0] OP_LDUR_VAL = 11'b11111000010;
    localparam logic [10:0] OP_STUR_VAL = 11'b11111000000;
    localparam logic [10:0] OP_FULL_MSK = 11'b11111111111;
    localparam logic [10:0] OP_CBZ_VAL  = 11'b10110100000;
    localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
    localparam logic [10:0] OP_B_VAL    = 11'b00010100000;
    localparam logic [10:0] OP_B_MASK   = 11'b11111100000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return (op & mask) == val;
    endfunction

endpackage

// File: rtl/legv8_opcode_classify.sv
// Pure combinational opcode -> instruction class decoder; first match wins.
module legv8_opcode_classify
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] i_opcode,
    output cls_e        o_class
);

    // Priority order R, LDUR, STUR, CBZ, B, else illegal
    always_comb begin
        o_class = CLS_ILL;
        if (op_match(i_opcode, OP_R_VAL, OP_R_MASK))             o_class = CLS_R;
        else if (op_match(i_opcode, OP_LDUR_VAL, OP_FULL_MSK))   o_class = CLS_LDUR;
        else if (op_match(i_opcode, OP_STUR_VAL, OP_FULL_MSK))   o_class = CLS_STUR;
        else if (op_match(i_opcode, OP_CBZ_VAL, OP_CBZ_MASK))    o_class = CLS_CBZ;
        else if (op_match(i_opcode, OP_B_VAL, OP_B_MASK))        o_class = CLS_B;
    end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multicycle LEGv8 control FSM: fetch/decode/execute/mem/wb sequencing,
// memory wait watchdog and illegal-opcode trap.
module legv8_multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter bit TRAP_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg2loc,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        uncond_branch,
    output logic [1:0]  alu_op,
    output logic        illegal_op,
    output logic        timeout,
    output logic [2:0]  state
);

    localparam int            CW     = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIM    = CW'(WAIT_LIMIT);
    localparam logic [CW-1:0] LIM_M1 = CW'(WAIT_LIMIT - 1);

    state_e        r_state, w_next;
    cls_e          r_class, w_class;
    logic [CW-1:0] r_cnt;
    logic          r_illegal, r_timeout;
    logic          w_set_ill, w_set_to, w_wait_exp;
    logic          w_imem_req, w_ir_write, w_pc_write, w_reg2loc, w_alu_src;
    logic          w_mem_to_reg, w_reg_write, w_mem_read, w_mem_write;
    logic          w_branch, w_uncond;
    logic [1:0]    w_alu_op;

    legv8_opcode_classify u_classify (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    // This is the last allowed wait cycle: a ready now is still accepted
    assign w_wait_exp = (r_cnt == LIM_M1);

    // State, class and sticky flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_class   <= CLS_ILL;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_class <= w_class;
            if (w_set_ill) r_illegal <= 1'b1;
            if (w_set_to)  r_timeout <= 1'b1;
        end
    end

    // Saturating wait counter, cleared on any state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_next != r_state)
            r_cnt <= '0;
        else if ((r_state == S_FETCH || r_state == S_MEM) && r_cnt != LIM)
            r_cnt <= r_cnt + 1'b1;
    end

    // Next-state logic and flag set strobes
    always_comb begin
        w_next    = r_state;
        w_set_ill = 1'b0;
        w_set_to  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ready) w_next = S_DECODE;
                else if (w_wait_exp) begin
                    w_next   = S_TRAP;
                    w_set_to = 1'b1;
                end
            end
            S_DECODE: begin
                case (w_class)
                    CLS_R:             w_next = S_EX_R;
                    CLS_LDUR, CLS_STUR: w_next = S_EX_ADDR;
                    CLS_CBZ, CLS_B:    w_next = S_BRANCH;
                    default: begin
                        if (TRAP_EN) begin
                            w_next    = S_TRAP;
                            w_set_ill = 1'b1;
                        end else begin
                            w_next = S_FETCH;
                        end
                    end
                endcase
            end
            S_EX_R:    w_next = S_WB;
            S_EX_ADDR: w_next = S_MEM;
            S_MEM: begin
                if (dmem_ready) w_next = (r_class == CLS_LDUR) ? S_WB : S_FETCH;
                else if (w_wait_exp) begin
                    w_next   = S_TRAP;
                    w_set_to = 1'b1;
                end
            end
            S_WB:     w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            default:  w_next = S_TRAP;
        endcase
    end

    // Datapath control decode from state and latched class
    always_comb begin
        w_imem_req   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg2loc    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_uncond     = 1'b0;
        w_alu_op     = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                w_ir_write = imem_ready;
                w_pc_write = imem_ready;
            end
            S_EX_R: w_alu_op = ALU_FUNCT;
            S_EX_ADDR: begin
                w_alu_src = 1'b1;
                w_reg2loc = (r_class == CLS_STUR);
            end
            S_MEM: begin
                w_alu_src   = 1'b1;
                w_mem_read  = (r_class == CLS_LDUR);
                w_mem_write = (r_class == CLS_STUR);
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_class == CLS_LDUR);
            end
            S_BRANCH: begin
                w_alu_op   = ALU_PASSB;
                w_reg2loc  = 1'b1;
                w_branch   = (r_class == CLS_CBZ);
                w_uncond   = (r_class == CLS_B);
                w_pc_write = (r_class == CLS_B) | ((r_class == CLS_CBZ) & zero);
            end
            default: ;
        endcase
    end

    // Everything reads zero while reset is held
    assign imem_req      = w_imem_req   & ~reset;
    assign ir_write      = w_ir_write   & ~reset;
    assign pc_write      = w_pc_write   & ~reset;
    assign reg2loc       = w_reg2loc    & ~reset;
    assign alu_src       = w_alu_src    & ~reset;
    assign mem_to_reg    = w_mem_to_reg & ~reset;
    assign reg_write     = w_reg_write  & ~reset;
    assign mem_read      = w_mem_read   & ~reset;
    assign mem_write     = w_mem_write  & ~reset;
    assign branch        = w_branch     & ~reset;
    assign uncond_branch = w_uncond     & ~reset;
    assign alu_op        = w_alu_op     & {2{~reset}};
    assign illegal_op    = r_illegal    & ~reset;
    assign timeout       = r_timeout    & ~reset;
    assign state         = r_state      & {3{~reset}};

endmodule
